// File: rtl/lbw_pkg.sv
// Shared definitions for the latch-bank write controller: FSM encoding,
// default geometry and a helper for index widths.
package lbw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 2;

  // A binary index needs at least one bit even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter
  import lbw_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] pointer,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(pointer) + k) % NREQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of gated-D latch cells: data is set up, the
// entry enable is strobed, then data is held, so a cell never sees data move while open.
module latch_bank_write_ctrl
  import lbw_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STROBE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr_in,
  input  logic [NREQ*WIDTH-1:0]  wdata_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DEPTH-1:0]       bank_en,
  output logic [WIDTH-1:0]       bank_d,
  output logic                   busy
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   win_reg, win_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NREQ-1:0]    gnt_reg, gnt_next;
  logic [NREQ-1:0]    done_reg, done_next;
  logic [DEPTH-1:0]   bank_en_reg, bank_en_next;
  logic [WIDTH-1:0]   bank_d_reg, bank_d_next;
  logic               busy_reg, busy_next;

  logic [NREQ-1:0]    arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [DEPTH-1:0]   entry_sel;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .pointer (ptr_reg),
    .onehot  (arb_onehot),
    .idx     (arb_idx),
    .valid   (arb_valid)
  );

  assign entry_sel = DEPTH'(1) << addr_reg;

  // Every output is decoded one cycle early so it leaves a flop.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    win_next     = win_reg;
    addr_next    = addr_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    done_next    = '0;
    bank_en_next = '0;
    bank_d_next  = bank_d_reg;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          win_next    = arb_idx;
          addr_next   = addr_in[arb_idx*ADDR_W +: ADDR_W];
          bank_d_next = wdata_in[arb_idx*WIDTH +: WIDTH];
          gnt_next    = arb_onehot;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        cnt_next     = '0;
        bank_en_next = entry_sel;
        state_next   = STROBE;
      end
      STROBE: begin
        if (cnt_reg == CNT_W'(STROBE_CYC - 1)) begin
          state_next = HOLD;
        end else begin
          cnt_next     = cnt_reg + 1'b1;
          bank_en_next = entry_sel;
        end
      end
      HOLD: begin
        done_next  = gnt_reg;
        state_next = DONE;
      end
      DONE: begin
        gnt_next   = '0;
        ptr_next   = (int'(win_reg) == NREQ - 1) ? '0 : win_reg + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      win_reg     <= '0;
      addr_reg    <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      bank_en_reg <= '0;
      bank_d_reg  <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      win_reg     <= win_next;
      addr_reg    <= addr_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      bank_en_reg <= bank_en_next;
      bank_d_reg  <= bank_d_next;
      busy_reg    <= busy_next;
    end
  end

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign bank_en = bank_en_reg;
  assign bank_d  = bank_d_reg;
  assign busy    = busy_reg;

endmodule

// File: doc/latch_bank_write_ctrl.md
Name: latch_bank_write_ctrl

Overview:
- Sequences write access to a shared bank of DEPTH level-sensitive D storage cells, each WIDTH bits wide, built from the team's NAND-based gated-D cells.
- Arbitrates round-robin between NREQ requesters.
- Drives a one-hot per-entry enable (the cell "clk" input) and a shared data bus with setup, strobe and hold phases, so a cell is never transparent while its data changes.
- Returns a grant/done handshake to the winning requester.

Parameters:
- NREQ, 2, number of requesters (2..4)
- WIDTH, 8, data bits per bank entry
- DEPTH, 4, number of bank entries (power of 2)
- ADDR_W, 2, log2(DEPTH)
- STROBE_CYC, 2, cycles the entry enable is held high (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester write request
- addr_in  in  NREQ*ADDR_W  packed entry addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata_in  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, high SETUP..DONE
- done  out  NREQ  one-cycle completion pulse to the granted requester
- bank_en  out  DEPTH  one-hot cell enable (cell clk input)
- bank_d  out  WIDTH  shared cell data bus
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, gnt=0, done=0, bank_en=0, bank_d=0, busy=0, RR pointer=0. All outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - If any req bit is high at an edge, choose the winner: the first set req at or after the pointer, wrapping modulo NREQ.
  - At that edge: capture the winner's addr and wdata into internal registers, set gnt[winner], drive bank_d=captured data, go to SETUP.
  - Otherwise remain in IDLE.
- SETUP: one cycle. bank_en=0, bank_d is stable. Next state is STROBE.
- STROBE:
  - bank_en[captured addr]=1 for exactly STROBE_CYC cycles, counted by an internal counter.
  - Then bank_en=0 and go to HOLD.
- HOLD: one cycle. bank_en=0, bank_d still stable. Next state is DONE.
- DONE:
  - done[winner]=1 for one cycle.
  - On exit: gnt=0, pointer=(winner+1) mod NREQ, return to IDLE.
- Latency:
  - req sampled at edge k puts gnt high from cycle k+1.
  - done is high in cycle k+3+STROBE_CYC.
  - Minimum spacing between back-to-back grants is 4+STROBE_CYC cycles, because IDLE lasts at least 1 cycle.
- bank_d rules:
  - bank_d changes only on the IDLE->SETUP edge.
  - bank_d holds its last value in IDLE. It is never cleared except by reset.
- Handshake rules:
  - addr and data are captured at grant. Later changes on addr_in or wdata_in are ignored.
  - Dropping req after grant does not abort the write; done still pulses.
  - A requester that holds req high through done is treated as a new request. Because the pointer has advanced past it, other pending requesters win first.
- Simultaneous requests: round-robin from the pointer. No requester waits more than NREQ-1 transactions.
- Reset mid-operation: bank_en, gnt, done and busy clear immediately (asynchronous). The interrupted write is lost; the cell content is undefined if reset lands in STROBE.
- Invariants:
  - At most one bank_en bit is high.
  - bank_en is high only in STROBE.
  - gnt is one-hot or zero.
  - done is a subset of gnt.

Decomposition:
- Shared package lbw_pkg holds:
  - state encoding constants (IDLE=0, SETUP=1, STROBE=2, HOLD=3, DONE=4; 3-bit)
  - default WIDTH, DEPTH and ADDR_W constants.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req, pointer
  - outputs: one-hot winner and its binary index
  - purely combinational; the pointer register stays in the parent.

Test Plan:
- Single write: reset, then req=01, addr0=2, wdata0=8'hA5. Expect gnt=01 from the next cycle; bank_d=A5 in SETUP; bank_en=0100 for exactly 2 cycles; done=01 at cycle k+5; busy low afterwards.
- Contention: req=11 at the same edge with pointer=0 → requester0 served first, then requester1 (holding req) is granted without servicing requester0 again. Pointer ends at 0.
- Data stability: after grant, change wdata0 from 8'h3C to 8'hFF. bank_d must stay 8'h3C through HOLD and bank_en must be 0 in SETUP and HOLD.
- Early req drop: deassert req0 one cycle after gnt → the transaction completes and done pulses once.
- Reset mid-STROBE: assert rst asynchronously during STROBE → bank_en, gnt and busy go 0 before the next edge. After release, a new req=10 is granted with pointer=0, so requester1 is chosen.
- Fairness with STROBE_CYC=1, NREQ=4: hold req=1111 for 20 transactions. Grants rotate 0,1,2,3,…, each req-to-done takes 4 cycles, and at most one bank_en bit is high in any cycle.
